ral_apb_slave: RTL

APB completer (slave) for the RAL environment: decodes the 4-bit APB address space into four 32-bit registers and answers initiator read and write transfers. The registers control a wrapping event counter with a sticky wrap flag and an interrupt. The block is the DUT side of the existing APB interface: it consumes PSEL, PENABLE, PWRITE, PADDR and PWDATA, and drives PRDATA, PREADY and PSLVERR.

---
 rtl/ral_pkg.sv | 30 +++
 rtl/ral_wrap_counter.sv | 28 ++
 rtl/ral_apb_slave.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/ral_pkg.sv
// Shared constants and types for the RAL APB completer: register map, CTRL bit
// positions, reset values and the APB transfer FSM encoding.
package ral_pkg;

    localparam logic [3:0] ADDR_CTRL   = 4'h0;
    localparam logic [3:0] ADDR_PERIOD = 4'h4;
    localparam logic [3:0] ADDR_COUNT  = 4'h8;
    localparam logic [3:0] ADDR_STATUS = 4'hC;

    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_CLR_BIT    = 1;
    localparam int unsigned CTRL_IRQ_EN_BIT = 2;

    localparam logic [2:0]  CTRL_RST   = 3'b000;
    localparam logic [31:0] PERIOD_RST = 32'h0000_00FF;
    localparam logic [31:0] COUNT_RST  = 32'h0000_0000;
    localparam logic        STATUS_RST = 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // Misaligned addresses and writes to the read-only COUNT get an error response.
    function automatic logic addr_err(input logic [3:0] addr, input logic write);
        return (addr[1:0] != 2'b00) || (write && (addr == ADDR_COUNT));
    endfunction

endpackage

// File: rtl/ral_wrap_counter.sv
// Wrapping event counter: counts up to PERIOD inclusive, then returns to 0 and
// pulses wrap for one cycle. A pending clear overrides counting.
module ral_wrap_counter
    import ral_pkg::*;
(
    input  logic        clk_sys,
    input  logic        rst_b,
    input  logic        en,
    input  logic        clr,
    input  logic [31:0] period,
    output logic [31:0] count,
    output logic        wrap
);

    // Wrap is still reported when a clear lands on the same cycle.
    assign wrap = en && (count == period);

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            count <= COUNT_RST;
        end else if (clr || wrap) begin
            count <= '0;
        end else if (en) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/ral_apb_slave.sv
// APB completer with CTRL/PERIOD/COUNT/STATUS registers driving a wrap counter.
// Build option RAL_SLV_WAIT_EN adds WAIT_STATES extra ACCESS cycles per transfer.
//
// state  | meaning
// IDLE   | waiting for a setup phase (PSEL=1, PENABLE=0)
// SETUP  | one cycle: decode address, capture transfer, latch PRDATA
// ACCESS | hold until wait count expires; PREADY and write commit on completion
module ral_apb_slave
    import ral_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [3:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        irq
);

    if (WAIT_STATES > 7) begin : g_wait_range
        $error("WAIT_STATES must be in 0..7");
    end

    apb_state_e  state_q, state_d;
    logic [3:0]  addr_q;
    logic        write_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic        access_done;
    logic        commit;

    logic        ctrl_en_q, ctrl_irq_en_q, clr_q;
    logic [31:0] period_q;
    logic        status_q;
    logic        irq_q;
    logic [31:0] count;
    logic        wrap;
    logic [31:0] rd_mux;

`ifdef RAL_SLV_WAIT_EN
    logic [2:0] wait_q;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_q <= '0;
        end else if (state_q == SETUP) begin
            wait_q <= WAIT_STATES[2:0];
        end else if ((state_q == ACCESS) && (wait_q != 3'd0)) begin
            wait_q <= wait_q - 3'd1;
        end
    end

    assign access_done = (wait_q == 3'd0);
`else
    assign access_done = 1'b1;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        PREADY  = 1'b0;
        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) state_d = SETUP;
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (access_done) begin
                    PREADY  = 1'b1;
                    state_d = (PSEL && !PENABLE) ? SETUP : IDLE;
                end else if (!PSEL) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign PSLVERR = PREADY && err_q;
    assign commit  = PREADY && write_q && !err_q;
    assign irq     = irq_q;

    always_comb begin
        rd_mux = '0;
        case (PADDR)
            ADDR_CTRL:   rd_mux = {29'd0, ctrl_irq_en_q, 1'b0, ctrl_en_q};
            ADDR_PERIOD: rd_mux = period_q;
            ADDR_COUNT:  rd_mux = count;
            ADDR_STATUS: rd_mux = {31'd0, status_q};
            default:     rd_mux = '0;
        endcase
    end

    // Transfer attributes are captured in SETUP so ACCESS does not depend on the bus.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            PRDATA  <= '0;
        end else if (state_q == SETUP) begin
            addr_q  <= PADDR;
            write_q <= PWRITE;
            wdata_q <= PWDATA;
            err_q   <= addr_err(PADDR, PWRITE);
            PRDATA  <= (PWRITE || addr_err(PADDR, PWRITE)) ? 32'd0 : rd_mux;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ctrl_en_q     <= CTRL_RST[CTRL_EN_BIT];
            ctrl_irq_en_q <= CTRL_RST[CTRL_IRQ_EN_BIT];
            clr_q         <= 1'b0;
            period_q      <= PERIOD_RST;
        end else begin
            clr_q <= 1'b0;
            if (commit && (addr_q == ADDR_CTRL)) begin
                ctrl_en_q     <= wdata_q[CTRL_EN_BIT];
                ctrl_irq_en_q <= wdata_q[CTRL_IRQ_EN_BIT];
                clr_q         <= wdata_q[CTRL_CLR_BIT];
            end
            if (commit && (addr_q == ADDR_PERIOD)) begin
                period_q <= wdata_q;
            end
        end
    end

    // A wrap in the same cycle as a W1C keeps the flag set.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            status_q <= STATUS_RST;
            irq_q    <= 1'b0;
        end else begin
            if (wrap) begin
                status_q <= 1'b1;
            end else if (commit && (addr_q == ADDR_STATUS) && wdata_q[0]) begin
                status_q <= 1'b0;
            end
            irq_q <= status_q && ctrl_irq_en_q;
        end
    end

    ral_wrap_counter u_counter (
        .clk_sys (PCLK),
        .rst_b   (PRESETn),
        .en      (ctrl_en_q),
        .clr     (clr_q),
        .period  (period_q),
        .count   (count),
        .wrap    (wrap)
    );

endmodule
